cb_operand_delay_line: RTL and testbench

Programmable operand staging block between a connection box output and a PE operand input. It delays the selected 16-bit track value by 0..DEPTH cycles, or substitutes a configured constant, so that operands arriving over routes of different length line up at the PE. It is configured over the same tile config bus as the connection box (config_addr / config_data / config_en). It tracks a valid bit alongside the data and supports a pipeline-wide stall.

---
 rtl/cb_operand_delay_line_if.sv | 41 ++++
 rtl/cb_operand_delay_line.sv | 143 ++++++++++++++
 tb/tb_cb_operand_delay_line.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cb_operand_delay_line_if.sv
// Purpose : bundles the config bus and operand stream of cb_operand_delay_line.
// Ports   : config_addr/config_data/config_en/read_data (tile config bus),
//           in/in_valid/stall (operand from connection box), out/out_valid (operand to PE).
// Modports: master drives config and operand input; slave is the delay line itself.
interface cb_operand_delay_line_if #(
   parameter int WIDTH = 16
);
   logic [31:0]      config_addr;
   logic [31:0]      config_data;
   logic             config_en;
   logic [31:0]      read_data;
   logic [WIDTH-1:0] in;
   logic             in_valid;
   logic             stall;
   logic [WIDTH-1:0] out;
   logic             out_valid;

   modport master (
      output config_addr,
      output config_data,
      output config_en,
      output in,
      output in_valid,
      output stall,
      input  read_data,
      input  out,
      input  out_valid
   );

   modport slave (
      input  config_addr,
      input  config_data,
      input  config_en,
      input  in,
      input  in_valid,
      input  stall,
      output read_data,
      output out,
      output out_valid
   );
endinterface

// File: rtl/cb_operand_delay_line.sv
// Purpose : programmable 0..DEPTH cycle operand delay (or constant substitution) between a
//           connection box output and a PE operand input, configured over the tile config bus.
// Latency : d cycles when const_mode=0 (d=0 is a combinational bypass); constant mode is static.
// Backpressure: stall=1 freezes every stage; the input sampled on a stalled edge is dropped.
// Ports   : i_clk, i_reset (synchronous, active-high), io_bus (cb_operand_delay_line_if.slave).
// Build option: CB_OPERAND_READBACK_EN -- when defined, read_data returns the stored config
//           register; when undefined, read_data is tied to zero and no readback mux exists.
module cb_operand_delay_line #(
   parameter int         WIDTH    = 16,    // 1..27, must match the interface WIDTH
   parameter int         DEPTH    = 4,     // 1..7
   parameter logic [7:0] REG_ADDR = 8'h00
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   cb_operand_delay_line_if.slave  io_bus
);

   localparam logic [2:0] DEPTH_L = 3'(DEPTH);

   // ------------------------------------------------------------------
   // Config register, held as separate fields. Bits outside these fields
   // always read back as zero, so they are never stored.
   // ------------------------------------------------------------------
   logic [2:0]       r_depth;
   logic             r_const_mode;
   logic [WIDTH-1:0] r_const_val;

   // Delay-line stages: r_stg_*[0] is the youngest sample.
   logic [DEPTH-1:0] r_stg_vld;
   logic [WIDTH-1:0] r_stg_dat [DEPTH];

   logic             w_wr;
   logic [2:0]       w_wr_depth;
   logic             w_tap_vld;
   logic [WIDTH-1:0] w_tap_dat;
   logic             w_out_vld;
   logic [WIDTH-1:0] w_out_dat;

   // Only the low address byte is decoded, and config_data above the
   // const_value field is discarded.
   wire w_unused = ^{io_bus.config_addr[31:8], io_bus.config_data[31:4+WIDTH]};

   assign w_wr = io_bus.config_en && (io_bus.config_addr[7:0] == REG_ADDR);

   // Requested depths beyond the physical line are clamped so that the tap
   // select can never point past the last stage.
   assign w_wr_depth = (io_bus.config_data[2:0] > DEPTH_L) ? DEPTH_L
                                                           : io_bus.config_data[2:0];

   // ------------------------------------------------------------------
   // Config register write
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_depth      <= 3'd0;
         r_const_mode <= 1'b0;
         r_const_val  <= '0;
      end else if (w_wr) begin
         r_depth      <= w_wr_depth;
         r_const_mode <= io_bus.config_data[3];
         r_const_val  <= io_bus.config_data[4 +: WIDTH];
      end
   end

   // ------------------------------------------------------------------
   // Delay line. Stages keep shifting in constant mode so that leaving
   // constant mode behaves like any other reconfiguration (flushed line).
   // A config write clears every valid bit; it is placed after the shift
   // so it wins over a valid sample entering s[0] on the same edge, and it
   // applies even while stalled. Stage data is deliberately left alone.
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_stg_vld <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_stg_dat[i] <= '0;
         end
      end else begin
         if (!io_bus.stall) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
               r_stg_vld[i] <= r_stg_vld[i-1];
               r_stg_dat[i] <= r_stg_dat[i-1];
            end
            r_stg_vld[0] <= io_bus.in_valid;
            r_stg_dat[0] <= io_bus.in;
         end
         if (w_wr) begin
            r_stg_vld <= '0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Tap select: stage d-1 for d>=1. Written as a compare loop so no
   // out-of-range index is ever formed for d=0.
   // ------------------------------------------------------------------
   always_comb begin
      w_tap_vld = 1'b0;
      w_tap_dat = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_depth == 3'(i + 1)) begin
            w_tap_vld = r_stg_vld[i];
            w_tap_dat = r_stg_dat[i];
         end
      end
   end

   // Output select. Only the d=0 bypass leg is combinational from the
   // input; the other legs are selected by static config from registers.
   always_comb begin
      w_out_vld = io_bus.in_valid;
      w_out_dat = io_bus.in;
      if (r_const_mode) begin
         w_out_vld = 1'b1;
         w_out_dat = r_const_val;
      end else if (r_depth != 3'd0) begin
         w_out_vld = w_tap_vld;
         w_out_dat = w_tap_dat;
      end
   end

   assign io_bus.out       = w_out_dat;
   assign io_bus.out_valid = w_out_vld;

   // ------------------------------------------------------------------
   // Readback
   // ------------------------------------------------------------------
`ifdef CB_OPERAND_READBACK_EN
   logic [31:0] w_cfg_rd;

   always_comb begin
      w_cfg_rd                = 32'h0;
      w_cfg_rd[2:0]           = r_depth;
      w_cfg_rd[3]             = r_const_mode;
      w_cfg_rd[4 +: WIDTH]    = r_const_val;
   end

   assign io_bus.read_data = w_cfg_rd;
`else
   assign io_bus.read_data = 32'h0;
`endif

endmodule

// File: tb/tb_cb_operand_delay_line.sv
module tb_cb_operand_delay_line;
   localparam int WIDTH = 16;

   typedef struct {
      int               cyc;
      logic [WIDTH-1:0] dat;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   bit   mon_en = 1'b0;
   exp_t sb_q[$];

   cb_operand_delay_line_if #(.WIDTH(WIDTH)) bus ();

   cb_operand_delay_line #(
      .WIDTH   (WIDTH),
      .DEPTH   (4),
      .REG_ADDR(8'h00)
   ) dut (
      .i_clk  (clk),
      .i_reset(rst),
      .io_bus (bus)
   );

   always #5 clk = ~clk;

   // Cycle number N covers the interval after the N-th rising edge.
   always @(posedge clk) cyc++;

   // Expected readback depends on whether readback hardware is built.
   function automatic logic [31:0] rb(input logic [31:0] v);
`ifdef CB_OPERAND_READBACK_EN
      return v;
`else
      return 32'h0 & v;
`endif
   endfunction

   // Monitor: every valid output must match the oldest expected entry in
   // both cycle and data; entries whose cycle has passed were never seen.
   always @(negedge clk) begin
      if (mon_en) begin
         while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL sb_missing: cycle %0d expected out=%h, no valid output seen",
                     sb_q[0].cyc, sb_q[0].dat);
            void'(sb_q.pop_front());
         end
         if (bus.out_valid === 1'b1) begin
            vectors++;
            if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
               if (bus.out !== sb_q[0].dat) begin
                  miscompares++;
                  $display("FAIL sb_data: cycle %0d out=%h, required %h", cyc, bus.out, sb_q[0].dat);
               end
               void'(sb_q.pop_front());
            end else begin
               miscompares++;
               $display("FAIL sb_unexpected: cycle %0d out_valid=1 out=%h, required out_valid=0",
                        cyc, bus.out);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic vld, input logic [WIDTH-1:0] dat, input logic stl);
      bus.in_valid = vld;
      bus.in       = dat;
      bus.stall    = stl;
   endtask

   task automatic expect_out(input int c, input logic [WIDTH-1:0] d);
      exp_t e;
      e.cyc = c;
      e.dat = d;
      sb_q.push_back(e);
   endtask

   task automatic send(input logic [WIDTH-1:0] d, input int dly);
      drive(1'b1, d, 1'b0);
      expect_out(cyc + dly, d);
      step();
   endtask

   task automatic idle(input int n);
      drive(1'b0, '0, 1'b0);
      repeat (n) step();
   endtask

   task automatic cfg_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic vld, input logic [WIDTH-1:0] dat);
      bus.config_en   = 1'b1;
      bus.config_addr = addr;
      bus.config_data = data;
      drive(vld, dat, 1'b0);
      step();
      bus.config_en = 1'b0;
      bus.in_valid  = 1'b0;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   initial begin
      int c0;
      int k;
      int m;
      int q;

      rst             = 1'b1;
      bus.config_en   = 1'b0;
      bus.config_addr = 32'h0;
      bus.config_data = 32'h0;
      drive(1'b0, '0, 1'b0);
      repeat (2) step();
      rst    = 1'b0;
      mon_en = 1'b1;

      // Reset state: bypass, nothing valid, readback zero.
      check("rst_read_data", bus.read_data, 32'h0);
      check("rst_out_valid", 32'(bus.out_valid), 32'h0);

      // Bypass after reset: same-cycle output.
      drive(1'b1, 16'h0004, 1'b0);
      expect_out(cyc, 16'h0004);
      #1;
      check("bypass_out", 32'(bus.out), 32'h4);
      check("bypass_vld", 32'(bus.out_valid), 32'h1);
      step();

      // d=3: values appear 3 cycles after they are driven.
      cfg_write(32'h0, 32'h3, 1'b0, '0);
      check("rd_d3", bus.read_data, rb(32'h3));
      send(16'd1, 3);
      send(16'd2, 3);
      send(16'd3, 3);
      send(16'd4, 3);
      idle(4);

      // d=3 with a 2-edge stall: output holds, later data gets +2 latency,
      // inputs offered during the stall are dropped.
      c0 = cyc;
      expect_out(c0 + 3, 16'd10);
      expect_out(c0 + 4, 16'd10);
      expect_out(c0 + 5, 16'd10);
      expect_out(c0 + 6, 16'd11);
      expect_out(c0 + 7, 16'd12);
      expect_out(c0 + 8, 16'd13);
      drive(1'b1, 16'd10, 1'b0); step();
      drive(1'b1, 16'd11, 1'b0); step();
      drive(1'b1, 16'd12, 1'b0); step();
      drive(1'b1, 16'h0099, 1'b1); step();
      drive(1'b1, 16'h009A, 1'b1); step();
      drive(1'b1, 16'd13, 1'b0); step();
      idle(4);

      // Constant mode: AB with valid regardless of input and stall.
      cfg_write(32'h0, 32'h0000_0AB8, 1'b0, '0);
      k = cyc;
      check("rd_const", bus.read_data, rb(32'h0000_0AB8));
      expect_out(k,     16'h00AB);
      expect_out(k + 1, 16'h00AB);
      expect_out(k + 2, 16'h00AB);
      expect_out(k + 3, 16'h00AB);
      drive(1'b1, 16'h0005, 1'b0);
      #1;
      check("const_out", 32'(bus.out), 32'h00AB);
      step();
      drive(1'b0, 16'h0006, 1'b1); step();
      drive(1'b1, 16'h0007, 1'b1); step();

      // Depth 7 saturates to 4; earlier stage contents are flushed.
      cfg_write(32'h0, 32'h7, 1'b0, '0);
      m = cyc;
      check("rd_sat", bus.read_data, rb(32'h4));
      send(16'd20, 4);
      send(16'd21, 4);
      // Write to another address: no config change, no flush.
      cfg_write(32'h0000_0001, 32'h0, 1'b0, '0);
      check("rd_other_addr", bus.read_data, rb(32'h4));
      idle(6);
      check("sat_lat_cycles", 32'(cyc - m), 32'd9);

      // d=2, full line, write coinciding with in_valid=1 flushes everything.
      // Upper address bits are not decoded, so this address still hits.
      cfg_write(32'h0, 32'h2, 1'b0, '0);
      q = cyc;
      check("rd_d2", bus.read_data, rb(32'h2));
      send(16'd30, 2);
      send(16'd31, 2);
      drive(1'b1, 16'd32, 1'b0); step();
      cfg_write(32'hFFFF_FF00, 32'h2, 1'b1, 16'd33);
      #1;
      check("flush_vld", 32'(bus.out_valid), 32'h0);
      idle(2);
      send(16'd40, 2);
      idle(3);
      check("flush_seq_cycles", 32'(cyc - q), 32'd10);

      // In-flight data, then reset together with a config write: reset wins.
      drive(1'b1, 16'd50, 1'b0); step();
      rst             = 1'b1;
      bus.config_en   = 1'b1;
      bus.config_addr = 32'h0;
      bus.config_data = 32'h0000_000B;
      drive(1'b0, '0, 1'b0);
      step();
      rst           = 1'b0;
      bus.config_en = 1'b0;
      check("rst_cfg_rd", bus.read_data, 32'h0);
      check("rst_discard_vld", 32'(bus.out_valid), 32'h0);
      step();
      drive(1'b1, 16'h0055, 1'b0);
      expect_out(cyc, 16'h0055);
      #1;
      check("rst_bypass_out", 32'(bus.out), 32'h55);
      step();
      idle(2);

      while (sb_q.size() > 0) begin
         vectors++;
         miscompares++;
         $display("FAIL sb_leftover: cycle %0d expected out=%h never observed",
                  sb_q[0].cyc, sb_q[0].dat);
         void'(sb_q.pop_front());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
